// File: rtl/waterfall_line_buf.sv
// waterfall_line_buf
//   Double-buffered line store for a waterfall display. ADC samples are
//   captured into the write bank while the display reads the other bank.
//   Each stored byte is turned into a false-colour RGB pixel.
//
// Ports
//   clk          pixel clock, all logic on the rising edge
//   reset        synchronous active-high reset
//   sample_valid one-cycle strobe for a new ADC sample
//   sample_data  ADC sample, top 8 bits are stored
//   line_start   one-cycle pulse at the start of each display line
//   pix_req      display consumes one pixel per cycle while high
//   rgb_data     registered pixel colour {R,G,B}
//   buf_ready    write bank is full and waiting for a swap
//   overrun      sticky, set when a sample is dropped
//
// Write FSM states
//   state | meaning
//   FILL  | write bank accepting samples at wr_addr
//   FULL  | write bank complete, samples dropped until line_start swaps

module waterfall_line_buf #(
  parameter int SAMPLE_WIDTH = 12,
  parameter int LINE_LEN     = 480
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    sample_valid,
  input  logic [SAMPLE_WIDTH-1:0] sample_data,
  input  logic                    line_start,
  input  logic                    pix_req,
  output logic [23:0]             rgb_data,
  output logic                    buf_ready,
  output logic                    overrun
);

  localparam int AW = (LINE_LEN > 1) ? $clog2(LINE_LEN) : 1;
  localparam logic [AW-1:0] LAST_ADDR = AW'(LINE_LEN - 1);

  typedef enum logic {FILL = 1'b0, FULL = 1'b1} state_t;

  // bank_sel_q = 0: write bank A, read bank B
  logic [7:0] mem_a [LINE_LEN];
  logic [7:0] mem_b [LINE_LEN];

  state_t        state_q, state_d;
  logic          bank_sel_q, bank_sel_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [AW-1:0] rd_addr_q, rd_addr_d;
  logic [23:0]   rgb_q, rgb_d;
  logic          buf_ready_q, buf_ready_d;
  logic          overrun_q, overrun_d;

  logic          mem_we;
  logic          mem_wbank;
  logic [AW-1:0] mem_waddr;
  logic [7:0]    mem_wdata;
  logic [7:0]    rd_byte;

  function automatic logic [23:0] color_map(input logic [7:0] v);
    logic [7:0] g;
    logic [7:0] b;
    g = v[7] ? {v[6:0], 1'b0} : 8'h00;
    b = v[7] ? 8'h00 : ~{v[6:0], 1'b0};
    return {v, g, b};
  endfunction

  assign rd_byte = bank_sel_q ? mem_a[rd_addr_q] : mem_b[rd_addr_q];

  always_comb begin
    state_d     = state_q;
    bank_sel_d  = bank_sel_q;
    wr_addr_d   = wr_addr_q;
    buf_ready_d = buf_ready_q;
    overrun_d   = overrun_q;
    mem_we      = 1'b0;
    mem_wbank   = bank_sel_q;
    mem_waddr   = wr_addr_q;
    mem_wdata   = sample_data[SAMPLE_WIDTH-1 -: 8];

    case (state_q)
      FILL: begin
        // line_start here deliberately does nothing to the write side:
        // the partial line is kept and the reader replays its old line.
        if (sample_valid) begin
          mem_we = 1'b1;
          if (wr_addr_q == LAST_ADDR) begin
            state_d     = FULL;
            buf_ready_d = 1'b1;
          end else begin
            wr_addr_d = wr_addr_q + AW'(1);
          end
        end
      end
      FULL: begin
        if (line_start) begin
          bank_sel_d  = ~bank_sel_q;
          state_d     = FILL;
          buf_ready_d = 1'b0;
          wr_addr_d   = '0;
          // Swap takes effect first, so a coincident sample lands at
          // address 0 of the freshly selected write bank.
          if (sample_valid) begin
            mem_we    = 1'b1;
            mem_wbank = ~bank_sel_q;
            mem_waddr = '0;
            wr_addr_d = AW'(1);
          end
        end else if (sample_valid) begin
          overrun_d = 1'b1;
        end
      end
      default: state_d = FILL;
    endcase

    rd_addr_d = rd_addr_q;
    rgb_d     = rgb_q;
    if (line_start) begin
      rd_addr_d = '0;
      rgb_d     = 24'h000000;
    end else if (pix_req) begin
      rgb_d = color_map(rd_byte);
      if (rd_addr_q != LAST_ADDR) begin
        rd_addr_d = rd_addr_q + AW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= FILL;
      bank_sel_q  <= 1'b0;
      wr_addr_q   <= '0;
      rd_addr_q   <= '0;
      rgb_q       <= 24'h000000;
      buf_ready_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      bank_sel_q  <= bank_sel_d;
      wr_addr_q   <= wr_addr_d;
      rd_addr_q   <= rd_addr_d;
      rgb_q       <= rgb_d;
      buf_ready_q <= buf_ready_d;
      overrun_q   <= overrun_d;
    end
  end

  // Memories are never cleared; reset only blocks writes in its own cycle.
  always_ff @(posedge clk) begin
    if (mem_we && !reset) begin
      if (mem_wbank) begin
        mem_b[mem_waddr] <= mem_wdata;
      end else begin
        mem_a[mem_waddr] <= mem_wdata;
      end
    end
  end

  assign rgb_data  = rgb_q;
  assign buf_ready = buf_ready_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_waterfall_line_buf.sv
// tb_waterfall_line_buf
//   Directed bench for waterfall_line_buf. Expected pixels are pushed to a
//   queue when pix_req / line_start are driven and popped one cycle later.

module tb_waterfall_line_buf;

  localparam int SW = 12;
  localparam int LL = 480;

  logic          clk = 1'b0;
  logic          reset;
  logic          sample_valid;
  logic [SW-1:0] sample_data;
  logic          line_start;
  logic          pix_req;
  logic [23:0]   rgb_data;
  logic          buf_ready;
  logic          overrun;

  int checks = 0;
  int errors = 0;

  // Bench view of the buffer: which bank is written, fill pointer, flags.
  logic [7:0]  mem_m [2][LL];
  int          wsel;
  int          wptr;
  bit          full_m;
  bit          ovr_m;
  logic [23:0] exp_q [$];
  logic [23:0] last_rgb;

  waterfall_line_buf #(.SAMPLE_WIDTH(SW), .LINE_LEN(LL)) dut (
    .clk          (clk),
    .reset        (reset),
    .sample_valid (sample_valid),
    .sample_data  (sample_data),
    .line_start   (line_start),
    .pix_req      (pix_req),
    .rgb_data     (rgb_data),
    .buf_ready    (buf_ready),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  // Colour map written arithmetically: red ramp, green rises in the top
  // half, blue falls across the bottom half.
  function automatic logic [23:0] cmap(input logic [7:0] v);
    int g;
    int b;
    g = (v >= 8'd128) ? (int'(v) - 128) * 2 : 0;
    b = (v < 8'd128) ? 255 - 2 * int'(v) : 0;
    return {v, 8'(g), 8'(b)};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_flags(input string tag);
    check({tag, ".buf_ready"}, 32'(buf_ready), 32'(full_m));
    check({tag, ".overrun"}, 32'(overrun), 32'(ovr_m));
  endtask

  task automatic model_write(input logic [SW-1:0] d);
    if (full_m) begin
      ovr_m = 1'b1;
    end else begin
      mem_m[wsel][wptr] = d[SW-1 -: 8];
      if (wptr == LL - 1) full_m = 1'b1;
      else wptr++;
    end
  endtask

  task automatic write_sample(input logic [SW-1:0] d);
    sample_valid = 1'b1;
    sample_data  = d;
    model_write(d);
    tick();
    sample_valid = 1'b0;
  endtask

  // Write samples whose stored byte is v, with junk in the low nibble.
  task automatic fill(input int first, input int count, input int mul, input int add);
    for (int i = first; i < first + count; i++) begin
      write_sample({8'((i * mul + add) % 256), 4'(i)});
    end
  endtask

  task automatic start_line(input bit with_pix, input bit with_sample, input logic [SW-1:0] d);
    line_start   = 1'b1;
    pix_req      = with_pix;
    sample_valid = with_sample;
    sample_data  = d;
    exp_q.push_back(24'h000000);
    if (full_m) begin
      wsel   = 1 - wsel;
      wptr   = 0;
      full_m = 1'b0;
      if (with_sample) model_write(d);
    end else if (with_sample) begin
      model_write(d);
    end
    tick();
    line_start   = 1'b0;
    pix_req      = 1'b0;
    sample_valid = 1'b0;
    last_rgb = exp_q.pop_front();
    check("line_start.rgb", rgb_data, last_rgb);
    check_flags("line_start");
  endtask

  task automatic read_pixels(input int n, input string tag);
    int rb;
    int idx;
    rb = 1 - wsel;
    for (int k = 0; k < n; k++) begin
      idx = (k < LL - 1) ? k : LL - 1;
      pix_req = 1'b1;
      exp_q.push_back(cmap(mem_m[rb][idx]));
      tick();
      last_rgb = exp_q.pop_front();
      check($sformatf("%s.pix%0d", tag, k), rgb_data, last_rgb);
    end
    pix_req = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    wsel = 0; wptr = 0; full_m = 1'b0; ovr_m = 1'b0;
    exp_q.delete();
    last_rgb = 24'h000000;
    tick();
    reset = 1'b0;
    sample_valid = 1'b0;
    line_start = 1'b0;
    pix_req = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    sample_valid = 1'b0;
    sample_data = '0;
    line_start = 1'b0;
    pix_req = 1'b0;
    tick();
    do_reset();
    check("reset.rgb", rgb_data, 24'h0);
    check_flags("reset");
    check("reset.wr_addr", 32'(dut.wr_addr_q), 0);

    // Line 1 into bank A: samples 0x000, 0x010, ... -> stored byte n mod 256
    for (int i = 0; i < LL; i++) begin
      write_sample(12'(i * 16));
      if (i == LL - 2) check("fill1.not_ready", 32'(buf_ready), 0);
    end
    check("fill1.buf_ready", 32'(buf_ready), 1);
    check("fill1.overrun", 32'(overrun), 0);

    // Swap and read line 1, running 5 past the end to hit saturation
    start_line(1'b0, 1'b0, '0);
    check("swap1.buf_ready", 32'(buf_ready), 0);
    read_pixels(LL + 5, "line1");
    check("line1.last", rgb_data, cmap(8'((LL - 1) % 256)));
    tick();
    check("hold.rgb", rgb_data, last_rgb);
    start_line(1'b1, 1'b0, '0);

    // Line 2 into bank B, then coincident line_start + sample in FULL
    fill(0, LL, 1, 3);
    check_flags("fill2");
    start_line(1'b0, 1'b1, 12'hFFF);
    check("coinc.wr_addr", 32'(dut.wr_addr_q), 1);
    check("coinc.overrun", 32'(overrun), 0);
    read_pixels(LL, "line2");

    // Rest of bank A, then a dropped sample sets overrun
    fill(1, LL - 1, 7, 0);
    check_flags("fill3");
    write_sample(12'h123);
    check("overrun.set", 32'(overrun), 1);
    start_line(1'b0, 1'b0, '0);
    check("overrun.sticky", 32'(overrun), 1);
    read_pixels(1, "line3p0");
    check("line3.pix0", rgb_data, 24'hFFFE00);
    start_line(1'b0, 1'b0, '0);
    read_pixels(LL, "line3");

    // Half fill bank B, line_start must not swap
    fill(0, LL / 2, 255, 255);
    start_line(1'b0, 1'b0, '0);
    check("half.wr_addr", 32'(dut.wr_addr_q), LL / 2);
    read_pixels(LL, "replay");
    fill(LL / 2, LL / 2 - 1, 3, 1);
    check("half.not_ready", 32'(buf_ready), 0);
    fill(LL - 1, 1, 3, 1);
    check_flags("half.done");
    start_line(1'b0, 1'b0, '0);
    read_pixels(LL, "line4");

    // Fill A, swap so B is written, start B, then reset mid-fill
    fill(0, LL, 1, 100);
    start_line(1'b0, 1'b0, '0);
    fill(0, 10, 1, 85);
    check("mid.wr_addr", 32'(dut.wr_addr_q), 10);
    sample_valid = 1'b1;
    sample_data = 12'hABC;
    line_start = 1'b1;
    pix_req = 1'b1;
    do_reset();
    check("rst2.rgb", rgb_data, 24'h0);
    check_flags("rst2");
    check("rst2.wr_addr", 32'(dut.wr_addr_q), 0);
    // Bank B keeps both the older line and the ten new entries
    start_line(1'b0, 1'b0, '0);
    read_pixels(LL, "post_rst");
    check_flags("end");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
